// File: rtl/cache_arbiter_pkg.sv
// Shared types for the two-cache physical-memory arbiter: FSM states,
// requester identifiers, widths and the round-robin pick.
package cache_arb_types;

  localparam int S_LINE = 256;
  localparam int S_ADDR = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

  // On a tie the requester that did not win last time is chosen.
  function automatic arb_req_t rr_select(input logic req_i, input logic req_d,
                                         input arb_req_t last_grant);
    arb_req_t sel;
    if (req_i && req_d) begin
      sel = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      sel = REQ_D;
    end else begin
      sel = REQ_I;
    end
    return sel;
  endfunction

endpackage

// File: rtl/cache_arbiter_checker.sv
// Protocol properties for the arbiter: no read+write from one requester,
// never both memory strobes at once.
module cache_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic i_read,
  input logic i_write,
  input logic d_read,
  input logic d_write,
  input logic pmem_read,
  input logic pmem_write
);

  a_i_single_op: assert property (@(posedge clk) disable iff (!rst) !(i_read && i_write));
  a_d_single_op: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
  a_pmem_one_strobe: assert property (@(posedge clk) disable iff (!rst) !(pmem_read && pmem_write));

endmodule

// File: rtl/cache_arbiter.sv
// Serialises whole-line I-cache and D-cache transactions onto one memory
// port, round-robin on ties, with latched request and returned line.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int s_line = S_LINE,
  parameter int s_addr = S_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [s_addr-1:0] i_address,
  input  logic [s_line-1:0] i_wdata,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_addr-1:0] d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_addr-1:0] pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_r;
  arb_state_t        state_s;
  arb_req_t          last_grant_r;
  arb_req_t          sel_s;
  logic              req_i_s;
  logic              req_d_s;
  logic              grant_s;
  logic              op_write_r;
  logic [s_addr-1:0] addr_r;
  logic [s_line-1:0] wdata_r;
  logic [s_line-1:0] i_rdata_r;
  logic [s_line-1:0] d_rdata_r;
  logic              i_resp_r;
  logic              d_resp_r;

  assign req_i_s = i_read | i_write;
  assign req_d_s = d_read | d_write;
  assign sel_s   = rr_select(req_i_s, req_d_s, last_grant_r);
  assign grant_s = (state_r == IDLE) && (req_i_s || req_d_s);

  // Next state and memory strobes; strobe falls in the pmem_resp cycle itself.
  always_comb begin
    state_s    = state_r;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = (sel_s == REQ_D) ? GRANT_D : GRANT_I;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        pmem_read  = !op_write_r && !pmem_resp;
        pmem_write = op_write_r && !pmem_resp;
        if (pmem_resp) begin
          state_s = RESP;
        end else begin
          state_s = state_r;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latches and tie-break history, loaded on grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= REQ_I;
      op_write_r   <= 1'b0;
      addr_r       <= {s_addr{1'b0}};
      wdata_r      <= {s_line{1'b0}};
    end else if (grant_s) begin
      if (sel_s == REQ_D) begin
        addr_r     <= d_address;
        wdata_r    <= d_wdata;
        op_write_r <= d_write;
      end else begin
        addr_r     <= i_address;
        wdata_r    <= i_wdata;
        op_write_r <= i_write;
      end
      if (req_i_s && req_d_s) begin
        last_grant_r <= sel_s;
      end
    end
  end

  // Completion strobes and returned lines, one per requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_resp_r  <= 1'b0;
      d_resp_r  <= 1'b0;
      i_rdata_r <= {s_line{1'b0}};
      d_rdata_r <= {s_line{1'b0}};
    end else begin
      i_resp_r <= (state_r == GRANT_I) && pmem_resp;
      d_resp_r <= (state_r == GRANT_D) && pmem_resp;
      if ((state_r == GRANT_I) && pmem_resp && !op_write_r) begin
        i_rdata_r <= pmem_rdata;
      end
      if ((state_r == GRANT_D) && pmem_resp && !op_write_r) begin
        d_rdata_r <= pmem_rdata;
      end
    end
  end

  assign i_rdata      = i_rdata_r;
  assign d_rdata      = d_rdata_r;
  assign i_resp       = i_resp_r;
  assign d_resp       = d_resp_r;
  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;

  cache_arbiter_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_write    (i_write),
    .d_read     (d_read),
    .d_write    (d_write),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a memory model records each served
// transaction and a monitor records every completion strobe.
`timescale 1ns/1ps
module tb_cache_arbiter;
  import cache_arb_types::*;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic         drop;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [7:0]   cycles;
  } txn_t;

  typedef struct packed {
    logic         is_d;
    logic [255:0] rdata;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read, i_write, d_read, d_write;
  logic [31:0]  i_address, d_address, pmem_address;
  logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
  logic         i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  txn_t exp_q[$], obs_q[$];
  rsp_t exp_r[$], rsp_q[$];
  int   obs_cyc_q[$], rsp_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_lat = 4;
  int   inject_req = 0;
  int   inject_done = 0;
  logic [255:0] mem_line = '0;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: answers after mem_lat strobe cycles, or pulses a stray resp on request.
  initial begin
    int   cnt;
    txn_t t;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (inject_done != inject_req) begin
        pmem_resp = 1'b1;
        inject_done = inject_req;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          t.rd = pmem_read;
          t.wr = pmem_write;
          t.addr = pmem_address;
          t.wdata = pmem_wdata;
          t.cycles = 8'(cnt);
          pmem_rdata = mem_line;
          pmem_resp = 1'b1;
          #1;
          t.drop = !(pmem_read || pmem_write);
          obs_q.push_back(t);
          obs_cyc_q.push_back(cyc);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Completion monitor.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (i_resp) begin rsp_q.push_back({1'b0, i_rdata}); rsp_cyc_q.push_back(cyc); end
      if (d_resp) begin rsp_q.push_back({1'b1, d_rdata}); rsp_cyc_q.push_back(cyc); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete required=finish");
    $fatal(1);
  end

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < budget) begin
      @(posedge clk); #3;
      k++;
    end
    ok = (rsp_q.size() >= n);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #3;
  endtask

  task automatic test_reset();
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
    repeat (2) @(posedge clk); #3;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes actual=%b required=0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    checks++;
    if ({pmem_address, pmem_wdata, i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_data actual=%h/%h required=0", pmem_address, i_rdata);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk); #3;
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00 || rsp_q.size() != 0) begin
      errors++; $display("FAIL reset_idle actual=%b/%0d required=00/0", {pmem_read, pmem_write}, rsp_q.size());
    end
  endtask

  task automatic test_i_read();
    bit ok; txn_t et, ot; rsp_t er, orr; int oc, rc;
    mem_lat = 4;
    mem_line = {32{8'hA5}};
    i_wdata = {8{32'h0BAD_F00D}};
    i_address = 32'h0000_1000;
    i_read = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 1'b1, 32'h0000_1000, {8{32'h0BAD_F00D}}, 8'd4});
    exp_r.push_back({1'b0, {32{8'hA5}}});
    @(posedge clk); #3;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_1000) begin
      errors++; $display("FAIL i_read_latency actual=%b/%h required=1/00001000", pmem_read, pmem_address);
    end
    wait_rsp(1, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL i_read_timeout actual=0 required=1 responses"); end
    i_read = 1'b0;
    repeat (4) @(posedge clk); #3;
    et = exp_q.pop_front(); er = exp_r.pop_front();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL i_read_txn_count actual=%0d required=1", obs_q.size());
    end else begin
      ot = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      checks++;
      if (ot !== et) begin errors++; $display("FAIL i_read_txn actual=%h required=%h", ot, et); end
      if (rsp_q.size() == 1) begin
        rc = rsp_cyc_q[0];
        checks++;
        if (rc != oc + 1) begin errors++; $display("FAIL i_read_resp_latency actual=%0d required=%0d", rc, oc + 1); end
      end
    end
    checks++;
    if (rsp_q.size() != 1) begin
      errors++; $display("FAIL i_read_resp_count actual=%0d required=1", rsp_q.size());
    end else begin
      orr = rsp_q.pop_front(); void'(rsp_cyc_q.pop_front());
      checks++;
      if (orr !== er) begin errors++; $display("FAIL i_read_resp actual=%h required=%h", orr, er); end
    end
  endtask

  task automatic test_d_write();
    bit ok; txn_t et, ot; rsp_t er, orr;
    mem_line = {32{8'h3C}};
    d_address = 32'h0000_2040;
    d_wdata = {8{32'hDEAD_BEEF}};
    d_write = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0000_2040, {8{32'hDEAD_BEEF}}, 8'd4});
    exp_r.push_back({1'b1, 256'h0});
    wait_rsp(1, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL d_write_timeout actual=0 required=1 responses"); end
    d_write = 1'b0;
    repeat (4) @(posedge clk); #3;
    et = exp_q.pop_front(); er = exp_r.pop_front();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL d_write_txn_count actual=%0d required=1", obs_q.size());
    end else begin
      ot = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      checks++;
      if (ot !== et) begin errors++; $display("FAIL d_write_txn actual=%h required=%h", ot, et); end
    end
    checks++;
    if (rsp_q.size() != 1) begin
      errors++; $display("FAIL d_write_resp_count actual=%0d required=1", rsp_q.size());
    end else begin
      orr = rsp_q.pop_front(); void'(rsp_cyc_q.pop_front());
      checks++;
      if (orr !== er) begin errors++; $display("FAIL d_write_resp actual=%h required=%h", orr, er); end
    end
    checks++;
    if (d_rdata !== 256'h0 || i_rdata !== {32{8'hA5}}) begin
      errors++; $display("FAIL d_write_rdata_hold actual=%h required=0", d_rdata);
    end
  endtask

  task automatic test_contention();
    bit ok; txn_t et, ot; rsp_t er, orr;
    apply_reset();
    mem_lat = 2;
    mem_line = {32{8'h5A}};
    i_address = 32'h0000_3000; i_wdata = {8{32'h1111_1111}};
    d_address = 32'h0000_4000; d_wdata = {8{32'h2222_2222}};
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) begin
        exp_q.push_back({1'b1, 1'b0, 1'b1, 32'h0000_4000, {8{32'h2222_2222}}, 8'd2});
        exp_r.push_back({1'b1, {32{8'h5A}}});
      end else begin
        exp_q.push_back({1'b1, 1'b0, 1'b1, 32'h0000_3000, {8{32'h1111_1111}}, 8'd2});
        exp_r.push_back({1'b0, {32{8'h5A}}});
      end
    end
    i_read = 1'b1; d_read = 1'b1;
    wait_rsp(4, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL contention_timeout actual=%0d required=4 responses", rsp_q.size()); end
    i_read = 1'b0; d_read = 1'b0;
    repeat (4) @(posedge clk); #3;
    while (exp_q.size() > 0) begin
      et = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL contention_txn actual=none required=%h", et); end
      else begin
        ot = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
        if (ot !== et) begin errors++; $display("FAIL contention_txn actual=%h required=%h", ot, et); end
      end
    end
    while (exp_r.size() > 0) begin
      er = exp_r.pop_front();
      checks++;
      if (rsp_q.size() == 0) begin errors++; $display("FAIL contention_resp actual=none required=%h", er); end
      else begin
        orr = rsp_q.pop_front(); void'(rsp_cyc_q.pop_front());
        if (orr !== er) begin errors++; $display("FAIL contention_resp actual=%h required=%h", orr, er); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || rsp_q.size() != 0) begin
      errors++; $display("FAIL contention_extra actual=%0d/%0d required=0/0", obs_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_fairness();
    bit ok; int k; txn_t et, ot; logic [31:0] a [3];
    apply_reset();
    mem_lat = 3;
    mem_line = {32{8'h77}};
    a[0] = 32'h0000_5000; a[1] = 32'h0000_6000; a[2] = 32'h0000_5000;
    i_address = 32'h0000_5000; i_wdata = '0;
    d_address = 32'h0000_6000; d_wdata = '0;
    for (int n = 0; n < 3; n++) exp_q.push_back({1'b1, 1'b0, 1'b1, a[n], 256'h0, 8'd3});
    i_read = 1'b1;
    k = 0;
    while (!pmem_read && k < 20) begin @(posedge clk); #3; k++; end
    checks++;
    if (pmem_read !== 1'b1) begin errors++; $display("FAIL fair_first_grant actual=%b required=1", pmem_read); end
    d_read = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      wait_rsp(n, 40, ok);
      if (ok && rsp_q[n-1].is_d) d_read = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL fair_timeout actual=%0d required=3 responses", rsp_q.size()); end
    i_read = 1'b0; d_read = 1'b0;
    repeat (4) @(posedge clk); #3;
    while (exp_q.size() > 0) begin
      et = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL fair_txn actual=none required=%h", et); end
      else begin
        ot = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
        if (ot !== et) begin errors++; $display("FAIL fair_txn actual=%h required=%h", ot, et); end
      end
    end
    rsp_q.delete(); rsp_cyc_q.delete();
  endtask

  task automatic test_reset_mid_grant();
    bit ok; int k; txn_t et, ot; rsp_t orr;
    mem_lat = 100;
    d_address = 32'h0000_7000; d_wdata = {8{32'h3333_3333}};
    d_read = 1'b1;
    k = 0;
    while (!pmem_read && k < 20) begin @(posedge clk); #3; k++; end
    @(posedge clk); #3;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_7000) begin
      errors++; $display("FAIL rst_mid_grant_pre actual=%b/%h required=1/00007000", pmem_read, pmem_address);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000 ||
        {pmem_address, pmem_wdata, i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs actual=%b/%h/%h required=0", {pmem_read, pmem_write, i_resp, d_resp}, pmem_address, i_rdata);
    end
    d_read = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    repeat (8) @(posedge clk); #3;
    checks++;
    if (rsp_q.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_no_resp actual=%0d/%0d required=0/0", rsp_q.size(), obs_q.size());
    end
    mem_lat = 3;
    i_address = 32'h0000_8000; i_wdata = {8{32'h4444_4444}};
    i_write = 1'b1;
    et = {1'b0, 1'b1, 1'b1, 32'h0000_8000, {8{32'h4444_4444}}, 8'd3};
    exp_q.push_back(et);
    wait_rsp(1, 30, ok);
    i_write = 1'b0;
    repeat (3) @(posedge clk); #3;
    et = exp_q.pop_front();
    checks++;
    if (!ok || obs_q.size() != 1 || rsp_q.size() != 1) begin
      errors++; $display("FAIL rst_mid_regrant actual=%0d/%0d required=1/1", obs_q.size(), rsp_q.size());
    end else begin
      ot = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      orr = rsp_q.pop_front(); void'(rsp_cyc_q.pop_front());
      checks++;
      if (ot !== et) begin errors++; $display("FAIL rst_mid_regrant_txn actual=%h required=%h", ot, et); end
      checks++;
      if (orr !== {1'b0, 256'h0}) begin errors++; $display("FAIL rst_mid_regrant_resp actual=%h required=0", orr); end
    end
  endtask

  task automatic test_idle_resp();
    bit ok; txn_t et, ot; rsp_t orr;
    mem_lat = 3;
    mem_line = {32{8'hC3}};
    inject_req = inject_req + 1;
    repeat (4) @(posedge clk); #3;
    checks++;
    if (rsp_q.size() != 0 || obs_q.size() != 0 || {pmem_read, pmem_write} !== 2'b00) begin
      errors++; $display("FAIL idle_resp_ignored actual=%0d/%b required=0/00", rsp_q.size(), {pmem_read, pmem_write});
    end
    d_address = 32'h0000_9000; d_wdata = {8{32'h5555_5555}};
    d_read = 1'b1;
    et = {1'b1, 1'b0, 1'b1, 32'h0000_9000, {8{32'h5555_5555}}, 8'd3};
    @(posedge clk); #3;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_9000) begin
      errors++; $display("FAIL idle_resp_still_idle actual=%b/%h required=1/00009000", pmem_read, pmem_address);
    end
    wait_rsp(1, 30, ok);
    d_read = 1'b0;
    repeat (3) @(posedge clk); #3;
    checks++;
    if (!ok || obs_q.size() != 1 || rsp_q.size() != 1) begin
      errors++; $display("FAIL idle_resp_txn_count actual=%0d/%0d required=1/1", obs_q.size(), rsp_q.size());
    end else begin
      ot = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      orr = rsp_q.pop_front(); void'(rsp_cyc_q.pop_front());
      checks++;
      if (ot !== et) begin errors++; $display("FAIL idle_resp_txn actual=%h required=%h", ot, et); end
      checks++;
      if (orr !== {1'b1, {32{8'hC3}}}) begin errors++; $display("FAIL idle_resp_rdata actual=%h required=%h", orr, {1'b1, {32{8'hC3}}}); end
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_fairness();
    test_reset_mid_grant();
    test_idle_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
